// File: rtl/text_overlay_pkg.sv
// text_overlay_pkg: shared mode and blink encodings plus the default marquee bitmap
package text_overlay_pkg;
    typedef enum logic [1:0] {
        STATIC       = 2'b00,
        SCROLL       = 2'b01,
        BLINK        = 2'b10,
        SCROLL_BLINK = 2'b11
    } mode_t;
    typedef enum logic {
        VISIBLE = 1'b0,
        HIDDEN  = 1'b1
    } blink_t;
    localparam logic [599:0] DEFAULT_BITMAP = {10{60'h0F0F0F0F0F0F0F1}};
    function automatic logic is_scroll(mode_t m);
        return m[0];
    endfunction
    function automatic logic is_blink(mode_t m);
        return m[1];
    endfunction
endpackage

// File: rtl/text_marquee_if.sv
// text_marquee_if: pixel position, frame control and marquee status signals
interface text_marquee_if #(parameter int BMP_W = 60);
    import text_overlay_pkg::*;
    localparam int SW = BMP_W > 1 ? $clog2(BMP_W) : 1;
    logic [9:0] x;
    logic [9:0] y;
    logic frame_start;
    logic enable;
    mode_t mode;
    logic overlay_active;
    logic [SW-1:0] scroll_pos;
    modport master (output x, y, frame_start, enable, mode, input overlay_active, scroll_pos);
    modport slave (input x, y, frame_start, enable, mode, output overlay_active, scroll_pos);
endinterface

// File: rtl/overlay_frame_timer.sv
// overlay_frame_timer: counts enabled ticks 0..DIV-1 and flags the wrapping tick
module overlay_frame_timer #(
    parameter int DIV = 4,
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic wrap
);
    logic [CW-1:0] count;
    assign wrap = enable && (count == CW'(DIV - 1));
    // count advances per enabled tick, restarting on wrap or clear
    always_ff @(posedge clk)
        if (reset || clear) count <= '0;
        else if (enable) count <= wrap ? '0 : count + 1'b1;
endmodule

// File: rtl/text_marquee.sv
// text_marquee: bitmap text overlay with optional horizontal scroll and blink
module text_marquee import text_overlay_pkg::*; #(
    parameter int BMP_W = 60,
    parameter int BMP_H = 10,
    parameter int SCALE_LOG2 = 3,
    parameter int ORIGIN_X = 11,
    parameter int ORIGIN_Y = 38,
    parameter int SCROLL_DIV = 4,
    parameter int BLINK_FRAMES = 30,
    parameter logic [BMP_W*BMP_H-1:0] BITMAP = (BMP_W*BMP_H)'(DEFAULT_BITMAP)
) (
    input logic clk,
    input logic reset,
    text_marquee_if.slave bus
);
    localparam int SW = BMP_W > 1 ? $clog2(BMP_W) : 1;
    localparam int IW = $clog2(BMP_W * BMP_H);
    mode_t mode_q, mode_eff;
    blink_t blink_q, blink_d;
    logic accepted, scroll_wrap, blink_wrap, visible, in_win, pix, overlay_q;
    logic [SW-1:0] pos;
    logic [9:0] cx, cy;
    logic [10:0] sum, col;
    logic [IW-1:0] idx;
    assign accepted = bus.frame_start && bus.enable;
    // a newly sampled mode governs the counters on the same frame_start
    assign mode_eff = accepted ? bus.mode : mode_q;
    overlay_frame_timer #(.DIV(SCROLL_DIV)) u_scroll_timer (
        .clk(clk),
        .reset(reset),
        .enable(accepted && is_scroll(mode_eff)),
        .clear(accepted && !is_scroll(mode_eff)),
        .wrap(scroll_wrap)
    );
    overlay_frame_timer #(.DIV(BLINK_FRAMES)) u_blink_timer (
        .clk(clk),
        .reset(reset),
        .enable(accepted && is_blink(mode_eff)),
        .clear(accepted && !is_blink(mode_eff)),
        .wrap(blink_wrap)
    );
    // latch the display mode only on accepted frame starts
    always_ff @(posedge clk)
        if (reset) mode_q <= STATIC;
        else if (accepted) mode_q <= bus.mode;
    // scroll offset steps on divider wrap and clears when scrolling stops
    always_ff @(posedge clk)
        if (reset || (accepted && !is_scroll(mode_eff))) pos <= '0;
        else if (scroll_wrap) pos <= (pos == SW'(BMP_W - 1)) ? '0 : pos + 1'b1;
    // blink state register
    always_ff @(posedge clk)
        if (reset) blink_q <= VISIBLE;
        else blink_q <= blink_d;
    // blink next state: forced visible outside blink modes, toggles on wrap
    always_comb begin
        blink_d = blink_q;
        if (accepted && !is_blink(mode_eff)) blink_d = VISIBLE;
        else if (blink_wrap) blink_d = (blink_q == VISIBLE) ? HIDDEN : VISIBLE;
    end
    // blink output decode
    always_comb visible = (blink_q == VISIBLE);
    // pixel to cell lookup; offsets wrap so pixels left/above the window fall out of range
    always_comb begin
        cx = (bus.x >> SCALE_LOG2) - 10'(ORIGIN_X);
        cy = (bus.y >> SCALE_LOG2) - 10'(ORIGIN_Y);
        in_win = (cx < 10'(BMP_W)) && (cy < 10'(BMP_H));
        sum = {1'b0, cx} + 11'(pos);
        col = (sum >= 11'(BMP_W)) ? sum - 11'(BMP_W) : sum;
        idx = IW'(32'(cy) * BMP_W + 32'(col));
        pix = in_win && BITMAP[idx];
    end
    // registered overlay flag uses pre-update scroll and blink state
    always_ff @(posedge clk)
        if (reset) overlay_q <= 1'b0;
        else overlay_q <= bus.enable && pix && visible;
    assign bus.overlay_active = overlay_q;
    assign bus.scroll_pos = pos;
endmodule

// File: tb/tb_text_marquee.sv
// tb_text_marquee: vector table, scenario sequences and randomized model comparison
module tb_text_marquee;
    import text_overlay_pkg::*;
    localparam logic [599:0] BMP = {5{120'h3C5A96F0E17B249_D1E07C3B59A8F64}};
    typedef struct {
        logic r;
        logic fs;
        logic en;
        mode_t md;
        int px;
        int py;
        logic ov;
        int pos;
    } vec_t;
    logic clk = 1'b0;
    logic reset;
    logic [599:0] bmp_v = BMP;
    int total = 0;
    int bad = 0;
    int sc = 0;
    int bl = 0;
    logic m_ov = 1'b0;
    vec_t tbl[14];
    always #5 clk = ~clk;
    text_marquee_if #(.BMP_W(60)) bus ();
    text_marquee #(.BITMAP(BMP)) dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic int m_pos();
        return (sc / 4) % 60;
    endfunction

    function automatic logic m_pix(int px, int py);
        int cxi = px / 8 - 11;
        int cyi = py / 8 - 38;
        if (cxi < 0 || cxi >= 60 || cyi < 0 || cyi >= 10) return 1'b0;
        return bmp_v[10'(cyi * 60 + (cxi + m_pos()) % 60)];
    endfunction

    task automatic cyc(input logic r, input logic fs, input logic en, input mode_t md, input int px, input int py);
        reset = r;
        bus.frame_start = fs;
        bus.enable = en;
        bus.mode = md;
        bus.x = 10'(px);
        bus.y = 10'(py);
        if (r) begin
            m_ov = 1'b0;
            sc = 0;
            bl = 0;
        end else begin
            m_ov = en && m_pix(px, py) && ((bl / 30) % 2 == 0);
            if (fs && en) begin
                sc = md[0] ? sc + 1 : 0;
                bl = md[1] ? bl + 1 : 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n, input mode_t md);
        repeat (n) cyc(1'b0, 1'b1, 1'b1, md, 0, 0);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic pixel(input string nm, input logic exp);
        cyc(1'b0, 1'b0, 1'b1, STATIC, 88, 328);
        check(nm, 32'(bus.overlay_active), 32'(exp));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, STATIC, 88, 328, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, STATIC, 88, 328, 1'b1, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, STATIC, 87, 328, 1'b0, 0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, STATIC, 568, 328, 1'b0, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, STATIC, 88, 303, 1'b0, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, STATIC, 88, 384, 1'b0, 0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, STATIC, 95, 335, 1'b1, 0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, STATIC, 96, 328, 1'b0, 0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, STATIC, 104, 336, 1'b1, 0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, STATIC, 88, 328, 1'b0, 0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, SCROLL, 88, 328, 1'b0, 0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, STATIC, 88, 328, 1'b1, 0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, STATIC, 88, 383, 1'b1, 0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, STATIC, 567, 304, 1'b1, 0};
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].r, tbl[i].fs, tbl[i].en, tbl[i].md, tbl[i].px, tbl[i].py);
            check($sformatf("vec%0d_ov", i), 32'(bus.overlay_active), 32'(tbl[i].ov));
            check($sformatf("vec%0d_pos", i), 32'(bus.scroll_pos), 32'(tbl[i].pos));
        end

        cyc(1'b1, 1'b0, 1'b1, STATIC, 0, 0);
        frames(3, SCROLL);
        check("scroll_3", 32'(bus.scroll_pos), 32'd0);
        frames(1, SCROLL);
        check("scroll_4", 32'(bus.scroll_pos), 32'd1);
        pixel("scroll_col1_pix", 1'b0);
        frames(235, SCROLL);
        check("scroll_239", 32'(bus.scroll_pos), 32'd59);
        frames(1, SCROLL);
        check("scroll_240", 32'(bus.scroll_pos), 32'd0);
        pixel("scroll_wrap_pix", 1'b1);

        cyc(1'b1, 1'b0, 1'b1, STATIC, 0, 0);
        frames(29, BLINK);
        pixel("blink_29_pix", 1'b1);
        frames(1, BLINK);
        pixel("blink_30_pix", 1'b0);
        check("blink_pos", 32'(bus.scroll_pos), 32'd0);
        frames(30, BLINK);
        pixel("blink_60_pix", 1'b1);

        cyc(1'b1, 1'b0, 1'b1, STATIC, 0, 0);
        frames(8, SCROLL);
        check("en_pre_pos", 32'(bus.scroll_pos), 32'd2);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 1'b0, SCROLL, 88, 328);
            check($sformatf("en_off%0d_ov", i), 32'(bus.overlay_active), 32'd0);
            check($sformatf("en_off%0d_pos", i), 32'(bus.scroll_pos), 32'd2);
        end

        cyc(1'b1, 1'b0, 1'b1, STATIC, 0, 0);
        frames(38, SCROLL);
        frames(30, SCROLL_BLINK);
        check("rst_pre_pos", 32'(bus.scroll_pos), 32'd17);
        pixel("rst_pre_hidden", 1'b0);
        cyc(1'b1, 1'b1, 1'b1, SCROLL, 88, 328);
        check("rst_pos", 32'(bus.scroll_pos), 32'd0);
        check("rst_ov", 32'(bus.overlay_active), 32'd0);
        pixel("rst_post_pix", 1'b1);

        begin
            mode_t md = STATIC;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 399) == 0) md = mode_t'($urandom_range(0, 3));
                cyc($urandom_range(0, 1499) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 9) != 0,
                    md, int'($urandom_range(70, 590)), int'($urandom_range(290, 400)));
                check("rand_ov", 32'(bus.overlay_active), 32'(m_ov));
                check("rand_pos", 32'(bus.scroll_pos), 32'(m_pos()));
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
